spi_slave_mem_arbiter: RTL and testbench

Two-to-one round-robin arbiter that shares a single OBI-style memory port between the SPI slave's bus-master path (requester 0) and a second on-chip master (requester 1, e.g. debug or DMA).
It locks the address phase until the grant, so OBI stability rules hold downstream.
It tracks outstanding transactions in a small in-order ID FIFO so each read/write response returns to the requester that issued it.
It sits between the SPI slave bus-adapter and the system bus/memory crossbar port.

---
 rtl/spi_slave_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_spi_slave_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mem_arbiter.sv
// Two-to-one round-robin arbiter sharing one OBI-style memory port between the SPI slave
// bus master (requester 0) and a second on-chip master (requester 1), with in-order response routing.
module spi_slave_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [1:0]                   req_i,
  input  logic [1:0]                   we_i,
  input  logic [1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [1:0][ADDR_WIDTH-1:0]   addr_i,
  input  logic [1:0][DATA_WIDTH-1:0]   wdata_i,
  output logic [1:0]                   gnt_o,
  output logic [1:0]                   rvalid_o,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [DATA_WIDTH/8-1:0]      mem_be_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [DATA_WIDTH-1:0]        mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_i,
  output logic                         err_o
);

  localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrWidth = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MAX_OUTSTANDING);
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(MAX_OUTSTANDING - 1);

  logic                       prio_q, prio_d;
  logic                       lock_q, lock_d;
  logic                       lock_sel_q, lock_sel_d;
  logic [MAX_OUTSTANDING-1:0] id_q, id_d;
  logic [PtrWidth-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]        cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic sel;
  logic full;
  logic grant;
  logic pop;
  logic head;

  // Arbitration and downstream drive; address-phase outputs are zeroed when not requesting.
  always_comb begin
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (&req_i) begin
      sel = prio_q;
    end else begin
      sel = req_i[1];
    end

    full        = (cnt_q == CntMax);
    mem_req_o   = req_i[sel] & ~full;
    mem_we_o    = mem_req_o & we_i[sel];
    mem_be_o    = mem_req_o ? be_i[sel]    : '0;
    mem_addr_o  = mem_req_o ? addr_i[sel]  : '0;
    mem_wdata_o = mem_req_o ? wdata_i[sel] : '0;

    grant      = mem_req_o & mem_gnt_i;
    gnt_o      = '0;
    gnt_o[sel] = grant;

    head           = id_q[rd_ptr_q];
    pop            = mem_rvalid_i & (cnt_q != '0);
    rvalid_o       = '0;
    rvalid_o[head] = pop;
    rdata_o        = mem_rdata_i;
    err_o          = err_q;
  end

  always_comb begin
    prio_d     = prio_q;
    lock_d     = lock_q;
    lock_sel_d = lock_sel_q;
    id_d       = id_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q | (mem_rvalid_i & (cnt_q == '0));

    if (grant) begin
      prio_d         = ~sel;
      lock_d         = 1'b0;
      id_d[wr_ptr_q] = sel;
      wr_ptr_d       = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end else if (mem_req_o) begin
      // Stalled address phase: keep presenting this requester until granted.
      lock_d     = 1'b1;
      lock_sel_d = sel;
    end

    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
      id_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      id_q       <= id_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_mem_arbiter.sv
// Bench for spi_slave_mem_arbiter: directed scenarios, then two random requesters against a
// random in-order memory, with a scoreboard of expected responses per requester.
module tb_spi_slave_mem_arbiter;

  localparam int MaxOut = 2;
  localparam int NTxn   = 60;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wire  [1:0]       req_i;
  wire  [1:0]       we_i;
  wire  [1:0][3:0]  be_i;
  wire  [1:0][31:0] addr_i;
  wire  [1:0][31:0] wdata_i;
  logic [1:0]       gnt_o;
  logic [1:0]       rvalid_o;
  logic [31:0]      rdata_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [3:0]       mem_be_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_wdata_o;
  wire              mem_gnt_i;
  wire              mem_rvalid_i;
  wire  [31:0]      mem_rdata_i;
  logic             err_o;

  // Directed-phase drive
  logic        rnd_mode = 1'b0;
  logic [1:0]  dir_req = '0;
  logic [1:0]  dir_we = '0;
  logic [3:0]  dir_be [2];
  logic [31:0] dir_addr [2];
  logic [31:0] dir_wdata [2];
  logic        dir_gnt = 1'b0;
  logic        dir_rv = 1'b0;
  logic [31:0] dir_rdata = '0;

  // Random-phase memory responder drive
  logic        rsp_gnt = 1'b0;
  logic        rsp_rv = 1'b0;
  logic [31:0] rsp_rdata = '0;

  assign mem_gnt_i    = rnd_mode ? rsp_gnt   : dir_gnt;
  assign mem_rvalid_i = rnd_mode ? rsp_rv    : dir_rv;
  assign mem_rdata_i  = rnd_mode ? rsp_rdata : dir_rdata;

  spi_slave_mem_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_i(req_i),
    .we_i(we_i),
    .be_i(be_i),
    .addr_i(addr_i),
    .wdata_i(wdata_i),
    .gnt_o(gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o(rdata_o),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i),
    .err_o(err_o)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  typedef struct {
    logic        wr;
    logic [31:0] data;
  } exp_t;
  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  logic [31:0] ref_mem [16];
  logic [31:0] dmem [16];
  logic [31:0] pend[$];
  int          m_held;
  int          m_last;
  int          m_out;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Random requesters: hold the request stable until granted, record expectation on grant.
  for (genvar g = 0; g < 2; g++) begin : g_drv
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;

    assign req_i[g]   = rnd_mode ? req   : dir_req[g];
    assign we_i[g]    = rnd_mode ? we    : dir_we[g];
    assign be_i[g]    = rnd_mode ? be    : dir_be[g];
    assign addr_i[g]  = rnd_mode ? addr  : dir_addr[g];
    assign wdata_i[g] = rnd_mode ? wdata : dir_wdata[g];

    initial begin
      int   gap;
      logic accepted;
      exp_t e;
      req = 1'b0; we = 1'b0; be = '0; addr = '0; wdata = '0; done = 1'b0;
      wait (rnd_mode);
      for (int n = 0; n < NTxn; n++) begin
        gap = int'($urandom_range(0, 2));
        if (gap > 0) begin
          @(posedge clk); #1;
          req = 1'b0;
          repeat (gap - 1) @(posedge clk);
        end
        @(posedge clk); #1;
        req   = 1'b1;
        we    = 1'($urandom_range(0, 1));
        be    = 4'($urandom());
        addr  = {26'd0, 4'($urandom()), 2'b00};
        wdata = $urandom();
        accepted = 1'b0;
        for (int k = 0; k < 200 && !accepted; k++) begin
          @(negedge clk);
          if (gnt_o[g]) begin
            accepted = 1'b1;
            e.wr   = we;
            e.data = ref_mem[addr[5:2]];
            if (we) ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wdata, be);
            if (g == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
          end
        end
        chk("grant_wait", accepted, 1);
        if (!accepted) break;
      end
      @(posedge clk); #1;
      req  = 1'b0;
      done = 1'b1;
    end
  end

  // In-order memory: random grant, random response spacing.
  initial begin
    wait (rnd_mode);
    forever begin
      @(posedge clk); #1;
      rsp_gnt = ($urandom_range(0, 9) < 7);
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        rsp_rv    = 1'b1;
        rsp_rdata = pend.pop_front();
      end else begin
        rsp_rv    = 1'b0;
        rsp_rdata = '0;
      end
    end
  end

  // Monitor: arbitration rules, memory side effects and response scoreboard.
  initial begin
    int         es;
    logic       exp_mreq;
    logic       pop;
    logic [1:0] exp_g;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rnd_mode && rst_n) begin
        if (m_held >= 0) es = m_held;
        else if (req_i == 2'b11) es = 1 - m_last;
        else es = req_i[1] ? 1 : 0;
        exp_mreq = req_i[es] && (m_out < MaxOut);
        exp_g    = (exp_mreq && mem_gnt_i) ? ((es == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk("arb_mem_req", mem_req_o, exp_mreq);
        chk("arb_gnt", gnt_o, exp_g);
        if (exp_mreq) chk("arb_mem_addr", mem_addr_o, addr_i[es]);

        if (mem_req_o && mem_gnt_i) begin
          if (mem_we_o) begin
            dmem[mem_addr_o[5:2]] = merge(dmem[mem_addr_o[5:2]], mem_wdata_o, mem_be_o);
            pend.push_back($urandom());
          end else begin
            pend.push_back(dmem[mem_addr_o[5:2]]);
          end
        end

        pop = mem_rvalid_i && (m_out > 0);
        chk("rsp_any", |rvalid_o, pop);
        if (rvalid_o[0]) begin
          chk("rsp0_expected", exp_q0.size() > 0, 1);
          if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            if (!e.wr) chk("rsp0_rdata", rdata_o, e.data);
          end
        end
        if (rvalid_o[1]) begin
          chk("rsp1_expected", exp_q1.size() > 0, 1);
          if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            if (!e.wr) chk("rsp1_rdata", rdata_o, e.data);
          end
        end

        if (exp_mreq && mem_gnt_i) begin
          m_last = es;
          m_held = -1;
          m_out++;
        end else if (exp_mreq) begin
          m_held = es;
        end
        if (pop) m_out--;
      end
    end
  end

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rd);
    @(posedge clk); #1;
    dir_req = req; dir_gnt = gnt; dir_rv = rv; dir_rdata = rd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    dir_req = '0; dir_gnt = 1'b0; dir_rv = 1'b0; dir_rdata = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] eg;
    for (int i = 0; i < 2; i++) begin
      dir_be[i] = 4'hF; dir_addr[i] = '0; dir_wdata[i] = '0;
    end
    dir_addr[0] = '0;
    dir_addr[1] = '0;

    // Reset state
    @(negedge clk);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_rvalid", rvalid_o, 2'b00);
    chk("rst_err", err_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_be", mem_be_o, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Single requester read
    dir_addr[0] = 32'h1000;
    drive(2'b01, 1, 0, 0);
    chk("single_gnt", gnt_o, 2'b01);
    chk("single_mem_req", mem_req_o, 1);
    chk("single_mem_addr", mem_addr_o, 32'h1000);
    chk("single_mem_we", mem_we_o, 0);
    chk("single_mem_be", mem_be_o, 4'hF);
    drive(2'b00, 0, 0, 0);
    chk("single_idle_req", mem_req_o, 0);
    drive(2'b00, 0, 1, 32'hDEADBEEF);
    chk("single_rvalid", rvalid_o, 2'b01);
    chk("single_rdata", rdata_o, 32'hDEADBEEF);
    drive(2'b00, 0, 0, 0);
    chk("single_rvalid_off", rvalid_o, 2'b00);

    // Contention with a response every cycle
    do_reset();
    dir_addr[0] = 32'h100;
    dir_addr[1] = 32'h200;
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 1, k > 0, 32'hA000 + 32'(k) - 32'd1);
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("cont_gnt", gnt_o, eg);
      chk("cont_addr", mem_addr_o, (k % 2 == 0) ? 32'h100 : 32'h200);
      if (k > 0) begin
        chk("cont_rvalid", rvalid_o, (k % 2 == 1) ? 2'b01 : 2'b10);
        chk("cont_rdata", rdata_o, 32'hA000 + 32'(k) - 32'd1);
      end
    end
    drive(2'b00, 0, 1, 32'hA003);
    chk("cont_rvalid_last", rvalid_o, 2'b10);

    // Lock: priority first moved to requester 1
    do_reset();
    drive(2'b01, 1, 0, 0);
    drive(2'b00, 0, 1, 32'h5);
    chk("lock_pre_rvalid", rvalid_o, 2'b01);
    dir_addr[0] = 32'hA0;
    dir_addr[1] = 32'hB0;
    drive(2'b01, 0, 0, 0);
    chk("lock_c0_addr", mem_addr_o, 32'hA0);
    chk("lock_c0_gnt", gnt_o, 2'b00);
    drive(2'b01, 0, 0, 0);
    drive(2'b11, 0, 0, 0);
    chk("lock_c2_addr", mem_addr_o, 32'hA0);
    chk("lock_c2_gnt", gnt_o, 2'b00);
    drive(2'b11, 1, 0, 0);
    chk("lock_gnt", gnt_o, 2'b01);
    chk("lock_gnt_addr", mem_addr_o, 32'hA0);
    drive(2'b11, 1, 0, 0);
    chk("lock_next_gnt", gnt_o, 2'b10);
    chk("lock_next_addr", mem_addr_o, 32'hB0);
    drive(2'b00, 0, 1, 32'h11);
    chk("lock_rsp0", rvalid_o, 2'b01);
    drive(2'b00, 0, 1, 32'h22);
    chk("lock_rsp1", rvalid_o, 2'b10);

    // Outstanding limit and simultaneous push/pop
    do_reset();
    drive(2'b01, 1, 0, 0);
    chk("lim_gnt0", gnt_o, 2'b01);
    drive(2'b10, 1, 0, 0);
    chk("lim_gnt1", gnt_o, 2'b10);
    drive(2'b01, 1, 0, 0);
    chk("lim_full_req", mem_req_o, 0);
    chk("lim_full_gnt", gnt_o, 2'b00);
    drive(2'b01, 1, 1, 32'h33);
    chk("lim_pop_req", mem_req_o, 0);
    chk("lim_pop_gnt", gnt_o, 2'b00);
    chk("lim_pop_rvalid", rvalid_o, 2'b01);
    drive(2'b01, 1, 0, 0);
    chk("lim_reopen_req", mem_req_o, 1);
    chk("lim_reopen_gnt", gnt_o, 2'b01);
    drive(2'b00, 0, 1, 32'h44);
    chk("lim_rsp1", rvalid_o, 2'b10);
    drive(2'b10, 1, 1, 32'h55);
    chk("pp_gnt", gnt_o, 2'b10);
    chk("pp_rvalid", rvalid_o, 2'b01);
    chk("pp_rdata", rdata_o, 32'h55);
    drive(2'b01, 1, 0, 0);
    chk("pp_cnt1_gnt", gnt_o, 2'b01);
    drive(2'b01, 1, 0, 0);
    chk("pp_cnt2_full", mem_req_o, 0);
    drive(2'b00, 0, 1, 32'h66);
    chk("pp_rsp_a", rvalid_o, 2'b10);
    drive(2'b00, 0, 1, 32'h77);
    chk("pp_rsp_b", rvalid_o, 2'b01);
    drive(2'b00, 0, 0, 0);
    chk("pp_err_clear", err_o, 0);

    // Spurious response and reset mid-transaction
    drive(2'b00, 0, 1, 32'h88);
    chk("spur_rvalid", rvalid_o, 2'b00);
    drive(2'b00, 0, 0, 0);
    chk("spur_err", err_o, 1);
    drive(2'b00, 0, 0, 0);
    chk("spur_err_sticky", err_o, 1);
    drive(2'b01, 1, 0, 0);
    drive(2'b01, 1, 0, 0);
    chk("mid_gnt", gnt_o, 2'b01);
    #2;
    rst_n = 1'b0;
    dir_req = '0; dir_gnt = 1'b0;
    #1;
    chk("mid_rst_err", err_o, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    drive(2'b00, 0, 1, 32'h99);
    chk("post_rst_rvalid", rvalid_o, 2'b00);
    drive(2'b11, 1, 0, 0);
    chk("post_rst_prio", gnt_o, 2'b01);
    chk("post_rst_err", err_o, 1);
    drive(2'b11, 1, 0, 0);
    chk("post_rst_gnt1", gnt_o, 2'b10);
    drive(2'b11, 1, 0, 0);
    chk("post_rst_full", mem_req_o, 0);
    drive(2'b00, 0, 1, 32'hAA);
    chk("post_rst_rsp0", rvalid_o, 2'b01);
    chk("post_rst_rdata", rdata_o, 32'hAA);
    drive(2'b00, 0, 1, 32'hBB);
    chk("post_rst_rsp1", rvalid_o, 2'b10);

    // Random phase
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h1111_1111);
      dmem[i]    = ref_mem[i];
    end
    m_held = -1;
    m_last = 1;
    m_out  = 0;
    rnd_mode = 1'b1;
    for (int k = 0; k < 20000 && !(g_drv[0].done && g_drv[1].done); k++) @(posedge clk);
    chk("drivers_done", g_drv[0].done && g_drv[1].done, 1);
    for (int k = 0; k < 500 && (exp_q0.size() + exp_q1.size()) > 0; k++) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", exp_q0.size() + exp_q1.size(), 0);
    chk("rnd_err", err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
